// File: rtl/rapcore_board_model_if.sv
// Pin bundle between the rapcore chip and its board model.
// master is the chip side, slave is the board model.
interface rapcore_board_model_if;
   logic PHASE_A1, PHASE_A2, PHASE_B1, PHASE_B2;
   logic PHASE_A1_H, PHASE_A2_H, PHASE_B1_H, PHASE_B2_H;
   logic analog_out1, analog_out2;
   logic analog_cmp1, analog_cmp2;
   logic CHARGEPUMP, BOOT_DONE_IN;
   logic STEPOUTPUT, DIROUTPUT, ENOUTPUT;
   logic ENC_A, ENC_B;
   logic STEPINPUT, DIRINPUT, ENINPUT;
   logic SCK, CS, COPI, CIPO;
   logic BUFFER_DTR, MOVE_DONE, HALT;

   modport master (
      output PHASE_A1, PHASE_A2, PHASE_B1, PHASE_B2,
             PHASE_A1_H, PHASE_A2_H, PHASE_B1_H, PHASE_B2_H,
             analog_out1, analog_out2, CHARGEPUMP, BOOT_DONE_IN,
             STEPOUTPUT, DIROUTPUT, ENOUTPUT, CIPO, BUFFER_DTR, MOVE_DONE,
      input  analog_cmp1, analog_cmp2, ENC_A, ENC_B,
             STEPINPUT, DIRINPUT, ENINPUT, SCK, CS, COPI, HALT
   );

   modport slave (
      input  PHASE_A1, PHASE_A2, PHASE_B1, PHASE_B2,
             PHASE_A1_H, PHASE_A2_H, PHASE_B1_H, PHASE_B2_H,
             analog_out1, analog_out2, CHARGEPUMP, BOOT_DONE_IN,
             STEPOUTPUT, DIROUTPUT, ENOUTPUT, CIPO, BUFFER_DTR, MOVE_DONE,
      output analog_cmp1, analog_cmp2, ENC_A, ENC_B,
             STEPINPUT, DIRINPUT, ENINPUT, SCK, CS, COPI, HALT
   );
endinterface

// File: rtl/rapcore_board_model.sv
// Board model around rapcore: two H-bridge coils with PWM-reference comparators,
// quadrature encoder from step/dir, and a host step generator gated by boot-done.
module rapcore_board_model #(
   parameter int COIL_STEP   = 16,
   parameter int DECAY_STEP  = 4,
   parameter int PWM_BITS    = 8,
   parameter int STEP_PERIOD = 64,
   parameter int STEP_COUNT  = 16
) (
   input logic                   CLK,
   input logic                   resetn_in,
   rapcore_board_model_if.slave  bus
);

   localparam logic signed [13:0] STEP_S  = 14'(COIL_STEP);
   localparam logic signed [13:0] DECAY_S = 14'(DECAY_STEP);
   localparam logic signed [13:0] IMAX    = 14'sd4095;
   localparam int TW  = $clog2(STEP_PERIOD + 1);
   localparam int CNW = $clog2(STEP_COUNT + 1);

   logic [1:0]               fwd, rev, shoot, aout;
   logic [1:0][12:0]         cur;
   logic [1:0][11:0]         tgt;
   logic [1:0][PWM_BITS:0]   hc;
   logic [PWM_BITS-1:0]      win;
   logic [1:0]               cmp;

   always_comb begin
      fwd   = {bus.PHASE_B1_H & bus.PHASE_B2, bus.PHASE_A1_H & bus.PHASE_A2};
      rev   = {bus.PHASE_B2_H & bus.PHASE_B1, bus.PHASE_A2_H & bus.PHASE_A1};
      shoot = {(bus.PHASE_B1_H & bus.PHASE_B1) | (bus.PHASE_B2_H & bus.PHASE_B2),
               (bus.PHASE_A1_H & bus.PHASE_A1) | (bus.PHASE_A2_H & bus.PHASE_A2)};
      aout  = {bus.analog_out2, bus.analog_out1};
   end

   // Any shoot-through or conflicting drive leaves the coil freewheeling.
   function automatic logic [12:0] next_cur(input logic [12:0] c, input logic f,
                                            input logic r, input logic s);
      logic signed [13:0] v, nv;
      v = $signed({c[12], c});
      if (f & ~r & ~s) begin
         nv = v + STEP_S;
         if (nv > IMAX) nv = IMAX;
      end else if (r & ~f & ~s) begin
         nv = v - STEP_S;
         if (nv < -IMAX) nv = -IMAX;
      end else if (v > DECAY_S) nv = v - DECAY_S;
      else if (v < -DECAY_S)    nv = v + DECAY_S;
      else                      nv = '0;
      return nv[12:0];
   endfunction

   function automatic logic [11:0] mag(input logic [12:0] c);
      logic [12:0] m;
      m = c[12] ? (~c + 13'd1) : c;
      return m[11:0];
   endfunction

   // A fully-high window scales to 4096; hold it at the 12-bit ceiling.
   function automatic logic [11:0] scale(input logic [PWM_BITS:0] h);
      logic [12:0] t;
      t = 13'(h) << (12 - PWM_BITS);
      return (t > 13'd4095) ? 12'd4095 : t[11:0];
   endfunction

   always_ff @(posedge CLK or negedge resetn_in) begin
      if (!resetn_in) begin
         cur <= '0;
         tgt <= '0;
         hc  <= '0;
         win <= '0;
         cmp <= 2'b11;
      end else begin
         win <= win + 1'b1;
         for (int i = 0; i < 2; i++) begin
            cmp[i] <= (mag(cur[i]) >= tgt[i]);
            cur[i] <= next_cur(cur[i], fwd[i], rev[i], shoot[i]);
            if (&win) begin
               tgt[i] <= scale(hc[i]);
               hc[i]  <= {{PWM_BITS{1'b0}}, aout[i]};
            end else begin
               hc[i]  <= hc[i] + {{PWM_BITS{1'b0}}, aout[i]};
            end
         end
      end
   end

   // Encoder: step edge detected from a sampled copy, position kept as a 2-bit count.
   logic       stp_s1, stp_s2;
   logic [1:0] pos;

   always_ff @(posedge CLK or negedge resetn_in) begin
      if (!resetn_in) begin
         stp_s1 <= 1'b0;
         stp_s2 <= 1'b0;
         pos    <= '0;
      end else begin
         stp_s1 <= bus.STEPOUTPUT;
         stp_s2 <= stp_s1;
         if (stp_s1 & ~stp_s2 & bus.ENOUTPUT)
            pos <= bus.DIROUTPUT ? pos + 2'd1 : pos - 2'd1;
      end
   end

   // Boot sync: second flop is itself the sticky flag.
   logic           boot_s1, booted, step;
   logic [TW-1:0]  tmr;
   logic [CNW-1:0] cnt;

   always_ff @(posedge CLK or negedge resetn_in) begin
      if (!resetn_in) begin
         boot_s1 <= 1'b0;
         booted  <= 1'b0;
         step    <= 1'b0;
         tmr     <= '0;
         cnt     <= '0;
      end else begin
         boot_s1 <= bus.BOOT_DONE_IN;
         booted  <= booted | boot_s1;
         step    <= 1'b0;
         if (booted && cnt != CNW'(STEP_COUNT)) begin
            if (tmr == TW'(STEP_PERIOD - 1)) begin
               tmr  <= '0;
               step <= 1'b1;
               cnt  <= cnt + 1'b1;
            end else begin
               tmr  <= tmr + 1'b1;
            end
         end
      end
   end

   assign bus.analog_cmp1 = cmp[0];
   assign bus.analog_cmp2 = cmp[1];
   assign bus.ENC_A       = pos[1];
   assign bus.ENC_B       = pos[1] ^ pos[0];
   assign bus.STEPINPUT   = step;
   assign bus.DIRINPUT    = booted;
   assign bus.ENINPUT     = booted;
   assign bus.CS          = 1'b1;
   assign bus.SCK         = 1'b0;
   assign bus.COPI        = 1'b0;
   assign bus.HALT        = 1'b0;

   logic unused_ok;
   assign unused_ok = ^{bus.CHARGEPUMP, bus.CIPO, bus.BUFFER_DTR, bus.MOVE_DONE};

endmodule

// File: tb/tb_rapcore_board_model.sv
// Bench for rapcore_board_model: encoder vector table, hand sequences for
// saturation/duty/boot, and a randomized coil run against a sample-history model.
module tb_rapcore_board_model;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rapcore_board_model_if bus ();
   rapcore_board_model dut (.CLK(clk), .resetn_in(rst_n), .bus(bus.slave));

   int n_cmp = 0;
   int n_bad = 0;

   int m_cur [2];
   int m_tgt [2];
   int m_cmp [2];
   int m_k;
   int qa [$];
   int qb [$];

   typedef struct { bit en; bit dir; logic [1:0] enc; } enc_vec_t;
   enc_vec_t tv [8];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int win_tgt(input int q[$]);
      int s = 0;
      foreach (q[i]) s += q[i];
      s = s * 16;
      return (s > 4095) ? 4095 : s;
   endfunction

   // Coil behaviour from the rules: which way (if any) the bridge pushes, then clamp.
   function automatic int coil(input int c, input bit h1, input bit l1, input bit h2, input bit l2);
      int d = 0;
      if (!((h1 && l1) || (h2 && l2))) begin
         if (h1 && l2 && !(h2 && l1)) d = 1;
         else if (h2 && l1 && !(h1 && l2)) d = -1;
      end
      if (d != 0) begin
         c = c + d * 16;
         if (c > 4095) c = 4095;
         if (c < -4095) c = -4095;
      end else if (c > 0) c = (c > 4) ? c - 4 : 0;
      else c = (c < -4) ? c + 4 : 0;
      return c;
   endfunction

   task automatic model_reset();
      m_cur = '{0, 0};
      m_tgt = '{0, 0};
      m_cmp = '{1, 1};
      m_k = 0;
      qa = {0};
      qb = {0};
   endtask

   task automatic tick();
      bit a1, a2, b1, b2, a1h, a2h, b1h, b2h, o1, o2;
      int ab0, ab1;
      {a1, a2, b1, b2} = {bus.PHASE_A1, bus.PHASE_A2, bus.PHASE_B1, bus.PHASE_B2};
      {a1h, a2h, b1h, b2h} = {bus.PHASE_A1_H, bus.PHASE_A2_H, bus.PHASE_B1_H, bus.PHASE_B2_H};
      {o1, o2} = {bus.analog_out1, bus.analog_out2};
      @(posedge clk);
      #1;
      if (!rst_n) model_reset();
      else begin
         ab0 = (m_cur[0] < 0) ? -m_cur[0] : m_cur[0];
         ab1 = (m_cur[1] < 0) ? -m_cur[1] : m_cur[1];
         m_cmp[0] = (ab0 >= m_tgt[0]) ? 1 : 0;
         m_cmp[1] = (ab1 >= m_tgt[1]) ? 1 : 0;
         m_k++;
         if (m_k % 256 == 0) begin
            m_tgt[0] = win_tgt(qa);
            m_tgt[1] = win_tgt(qb);
         end
         qa.push_back(int'(o1));
         qb.push_back(int'(o2));
         if (qa.size() > 256) void'(qa.pop_front());
         if (qb.size() > 256) void'(qb.pop_front());
         m_cur[0] = coil(m_cur[0], a1h, a1, a2h, a2);
         m_cur[1] = coil(m_cur[1], b1h, b1, b2h, b2);
      end
      chk("model_cmp1", int'(bus.analog_cmp1), m_cmp[0]);
      chk("model_cmp2", int'(bus.analog_cmp2), m_cmp[1]);
      chk("model_cur_a", int'($signed(dut.cur[0])), m_cur[0]);
      chk("model_cur_b", int'($signed(dut.cur[1])), m_cur[1]);
   endtask

   task automatic gates_off();
      {bus.PHASE_A1, bus.PHASE_A2, bus.PHASE_B1, bus.PHASE_B2} = 4'b0;
      {bus.PHASE_A1_H, bus.PHASE_A2_H, bus.PHASE_B1_H, bus.PHASE_B2_H} = 4'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int pulses, t, bad;
      bit exp_s;
      tv[0] = '{1, 1, 2'b01}; tv[1] = '{1, 1, 2'b11}; tv[2] = '{1, 1, 2'b10};
      tv[3] = '{1, 1, 2'b00}; tv[4] = '{1, 1, 2'b01}; tv[5] = '{1, 0, 2'b00};
      tv[6] = '{0, 1, 2'b00}; tv[7] = '{0, 0, 2'b00};

      gates_off();
      {bus.analog_out1, bus.analog_out2, bus.CHARGEPUMP, bus.BOOT_DONE_IN} = 4'b0;
      {bus.STEPOUTPUT, bus.DIROUTPUT, bus.ENOUTPUT} = 3'b0;
      {bus.CIPO, bus.BUFFER_DTR, bus.MOVE_DONE} = 3'b0;
      model_reset();

      // Reset values, with noisy inputs held during reset
      rst_n = 1'b0;
      bus.CHARGEPUMP = 1'b1; bus.BOOT_DONE_IN = 1'b1; bus.CIPO = 1'b1;
      bus.PHASE_A1_H = 1'b1; bus.PHASE_A2 = 1'b1; bus.STEPOUTPUT = 1'b1; bus.ENOUTPUT = 1'b1;
      repeat (3) tick();
      chk("rst_cmp1", int'(bus.analog_cmp1), 1);
      chk("rst_cmp2", int'(bus.analog_cmp2), 1);
      chk("rst_enc", int'({bus.ENC_A, bus.ENC_B}), 0);
      chk("rst_stepin", int'(bus.STEPINPUT), 0);
      chk("rst_dirin", int'(bus.DIRINPUT), 0);
      chk("rst_enin", int'(bus.ENINPUT), 0);
      chk("rst_cs", int'(bus.CS), 1);
      chk("rst_sck", int'(bus.SCK), 0);
      chk("rst_copi", int'(bus.COPI), 0);
      chk("rst_halt", int'(bus.HALT), 0);
      chk("rst_tgt_a", int'(dut.tgt[0]), 0);
      gates_off();
      {bus.CHARGEPUMP, bus.BOOT_DONE_IN, bus.CIPO, bus.STEPOUTPUT, bus.ENOUTPUT} = 5'b0;
      rst_n = 1'b1;

      // Forward saturation then decay to exactly zero
      bus.PHASE_A1_H = 1'b1; bus.PHASE_A2 = 1'b1;
      repeat (300) tick();
      chk("sat_a", int'($signed(dut.cur[0])), 4095);
      gates_off();
      tick();
      chk("decay_first", int'($signed(dut.cur[0])), 4091);
      repeat (1022) tick();
      chk("decay_3", int'($signed(dut.cur[0])), 3);
      tick();
      chk("decay_0", int'($signed(dut.cur[0])), 0);
      repeat (4) tick();
      chk("decay_hold0", int'($signed(dut.cur[0])), 0);

      // Shoot-through and conflicting drive are undriven
      bus.PHASE_A1_H = 1'b1; bus.PHASE_A2 = 1'b1;
      repeat (20) tick();
      bus.PHASE_A1 = 1'b1;
      tick();
      chk("shoot_a", int'($signed(dut.cur[0])), 316);
      gates_off();
      bus.PHASE_B2_H = 1'b1; bus.PHASE_B1 = 1'b1;
      repeat (10) tick();
      chk("rev_b", int'($signed(dut.cur[1])), -160);
      bus.PHASE_B2 = 1'b1;
      tick();
      chk("shoot_b", int'($signed(dut.cur[1])), -156);
      gates_off();

      // 50% duty reference then forward drive through the threshold
      do_reset();
      for (int k = 1; k <= 256; k++) begin
         bus.analog_out1 = k[0];
         tick();
      end
      chk("duty_tgt_a", int'(dut.tgt[0]), 2048);
      bus.PHASE_A1_H = 1'b1; bus.PHASE_A2 = 1'b1;
      for (int j = 1; j <= 129; j++) begin
         bus.analog_out1 = ~bus.analog_out1;
         tick();
         if (j == 1)   chk("duty_cmp_start", int'(bus.analog_cmp1), 0);
         if (j == 128) chk("duty_cmp_below", int'(bus.analog_cmp1), 0);
         if (j == 129) chk("duty_cmp_reach", int'(bus.analog_cmp1), 1);
      end
      gates_off();
      bus.analog_out1 = 1'b0;

      // Encoder vectors: two-cycle latency from STEPOUTPUT rise
      for (int i = 0; i < 8; i++) begin
         bus.ENOUTPUT = tv[i].en; bus.DIROUTPUT = tv[i].dir;
         bus.STEPOUTPUT = 1'b1;
         tick();
         if (i == 0) chk("enc_latency", int'({bus.ENC_A, bus.ENC_B}), 0);
         bus.STEPOUTPUT = 1'b0;
         tick();
         chk($sformatf("enc_vec%0d", i), int'({bus.ENC_A, bus.ENC_B}), int'(tv[i].enc));
         repeat (2) tick();
      end

      // Boot: flag after two cycles, 16 pulses 64 apart, glitch ignored
      do_reset();
      bus.BOOT_DONE_IN = 1'b1;
      tick();
      chk("boot_dir_early", int'(bus.DIRINPUT), 0);
      tick();
      chk("boot_dir", int'(bus.DIRINPUT), 1);
      chk("boot_en", int'(bus.ENINPUT), 1);
      pulses = 0;
      bad = 0;
      for (t = 1; t <= 64 * 18; t++) begin
         bus.BOOT_DONE_IN = (t == 1) ? 1'b0 : 1'b1;
         tick();
         exp_s = (t % 64 == 0) && (t / 64 <= 16);
         if (bus.STEPINPUT) pulses++;
         if (bus.STEPINPUT != exp_s) bad++;
      end
      chk("step_pulses", pulses, 16);
      chk("step_timing_errs", bad, 0);
      chk("boot_glitch_dir", int'(bus.DIRINPUT), 1);

      // Mid-run reset clears the generator; restarts only on a fresh boot-done
      do_reset();
      repeat (200) tick();
      bus.BOOT_DONE_IN = 1'b0;
      do_reset();
      pulses = 0;
      for (int i = 0; i < 150; i++) begin
         tick();
         pulses += int'(bus.STEPINPUT) + int'(bus.DIRINPUT);
      end
      chk("idle_after_reset", pulses, 0);
      bus.BOOT_DONE_IN = 1'b1;
      repeat (2) tick();
      repeat (63) tick();
      chk("restart_pre", int'(bus.STEPINPUT), 0);
      tick();
      chk("restart_first", int'(bus.STEPINPUT), 1);

      // Randomized coil drive and PWM reference against the model
      do_reset();
      for (int s = 0; s < 16; s++) begin
         int ma, mb, len, da, db;
         ma = $urandom_range(0, 3); mb = $urandom_range(0, 3);
         len = $urandom_range(50, 200);
         da = $urandom_range(0, 100); db = $urandom_range(0, 100);
         for (int c = 0; c < len; c++) begin
            logic [3:0] r;
            r = 4'($urandom);
            case (ma)
               0: {bus.PHASE_A1_H, bus.PHASE_A1, bus.PHASE_A2_H, bus.PHASE_A2} = 4'b1001;
               1: {bus.PHASE_A1_H, bus.PHASE_A1, bus.PHASE_A2_H, bus.PHASE_A2} = 4'b0110;
               2: {bus.PHASE_A1_H, bus.PHASE_A1, bus.PHASE_A2_H, bus.PHASE_A2} = 4'b0000;
               default: {bus.PHASE_A1_H, bus.PHASE_A1, bus.PHASE_A2_H, bus.PHASE_A2} = r;
            endcase
            r = 4'($urandom);
            case (mb)
               0: {bus.PHASE_B1_H, bus.PHASE_B1, bus.PHASE_B2_H, bus.PHASE_B2} = 4'b1001;
               1: {bus.PHASE_B1_H, bus.PHASE_B1, bus.PHASE_B2_H, bus.PHASE_B2} = 4'b0110;
               2: {bus.PHASE_B1_H, bus.PHASE_B1, bus.PHASE_B2_H, bus.PHASE_B2} = 4'b0000;
               default: {bus.PHASE_B1_H, bus.PHASE_B1, bus.PHASE_B2_H, bus.PHASE_B2} = r;
            endcase
            bus.analog_out1 = ($urandom_range(0, 99) < da);
            bus.analog_out2 = ($urandom_range(0, 99) < db);
            tick();
         end
      end
      gates_off();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/rapcore_board_model.md
# rapcore_board_model

Board-level behavioural model of the external hardware around the rapcore stepper controller, placed beside the chip top-level in system simulation on the user GPIO pins. It models two H-bridge coils whose current follows the gate signals, turns the analog PWM reference into comparator feedback, converts step/dir outputs into quadrature encoder signals, and drives the host-side step/dir/SPI/halt pins.

## Interface
Parameters:
- COIL_STEP, 16: current increment per driven cycle (LSB units)
- DECAY_STEP, 4: current decrement toward 0 per undriven cycle
- PWM_BITS, 8: duty-measurement window is 2^PWM_BITS cycles
- STEP_PERIOD, 64: cycles between generated STEPINPUT pulses
- STEP_COUNT, 16: number of STEPINPUT pulses generated after boot

Ports:
- CLK  in  1  single clock
- resetn_in  in  1  asynchronous, active-low reset
- PHASE_A1, PHASE_A2, PHASE_B1, PHASE_B2  in  1 each  low-side gates
- PHASE_A1_H, PHASE_A2_H, PHASE_B1_H, PHASE_B2_H  in  1 each  high-side gates
- analog_out1, analog_out2  in  1 each  PWM current reference, coil A / B
- analog_cmp1, analog_cmp2  out  1 each  comparator: coil current reached reference
- CHARGEPUMP  in  1  charge-pump clock (monitored only)
- BOOT_DONE_IN  in  1  chip boot complete
- STEPOUTPUT, DIROUTPUT, ENOUTPUT  in  1 each  step/dir/enable from chip
- ENC_A, ENC_B  out  1 each  quadrature encoder to chip
- STEPINPUT, DIRINPUT, ENINPUT  out  1 each  host step/dir/enable to chip
- SCK, CS, COPI  out  1 each  SPI master (idle only); CIPO  in  1
- BUFFER_DTR, MOVE_DONE  in  1 each  status (monitored only); HALT  out  1

## Operation
- Coil A: forward drive when PHASE_A1_H & PHASE_A2; reverse when PHASE_A2_H & PHASE_A1. Both or neither (incl. shoot-through A1_H&A1 or A2_H&A2) = undriven. Coil B same with B pins.
- Coil current: 13-bit signed register. Forward: +COIL_STEP, saturate at +4095. Reverse: −COIL_STEP, saturate at −4095. Undriven: move DECAY_STEP toward 0, clamp at 0 (never overshoots sign).
- Duty measure per coil: free-running window counter of PWM_BITS bits shared by both coils; high-count increments each cycle analog_outN=1. On window wrap, target_N <= high_count << (12−PWM_BITS) (unsigned 12-bit) and high_count clears (counting the wrap cycle as first of new window).
- analog_cmpN = 1 when |currentN| >= target_N, else 0; registered.
- Encoder: 2-bit Gray state, {ENC_A,ENC_B} = 00→01→11→10→00 when DIROUTPUT=1, reverse order when 0; advances one state per STEPOUTPUT rising edge (edge-detected via registered copy) only while ENOUTPUT=1.
- Boot gating: BOOT_DONE_IN synchronized through 2 flops; sticky boot flag set on its first 1.
- Step generator: after boot flag, emits STEP_COUNT pulses on STEPINPUT, each 1 cycle high, spaced STEP_PERIOD cycles, first pulse STEP_PERIOD cycles after boot flag; then idle. DIRINPUT=1 and ENINPUT=1 once boot flag set.
- SPI held idle: CS=1, SCK=0, COPI=0. HALT=0 always. CHARGEPUMP, CIPO, BUFFER_DTR, MOVE_DONE are ignored.

## Timing
- Reset (resetn_in=0, async): currents 0, targets 0, window and high counts 0, analog_cmp1/2=1 (|0|>=0), ENC_A=ENC_B=0, STEPINPUT=0, DIRINPUT=0, ENINPUT=0, CS=1, SCK=0, COPI=0, HALT=0, boot flag 0, pulse counter 0.
- Current updates on CLK rising edge from that cycle's gates; analog_cmp reflects the updated current one cycle later.
- target updates on the edge at window wrap; first valid target 2^PWM_BITS cycles after reset.
- Encoder output changes 2 cycles after STEPOUTPUT rising edge (sample + edge detect).
- Boot flag 2 cycles after BOOT_DONE_IN rises; BOOT_DONE_IN glitch once latched has no effect.
- Reset mid-operation clears everything, including pulse count; generator restarts only after a new boot-done.

## Test plan
- Reset: hold resetn_in=0 -> all outputs at listed reset values, analog_cmp1/2=1.
- Forward drive A (A1_H=1, A2=1) 300 cycles -> current A = 4095 saturated; release -> decays by 4/cycle to exactly 0.
- analog_out1 at 50% duty (PWM_BITS=8) -> target_A=128<<4=2048; drive forward -> analog_cmp1 goes 0→1 one cycle after current ≥2048.
- ENOUTPUT=1, DIROUTPUT=1, 5 STEPOUTPUT pulses -> ENC sequence 01,11,10,00,01; DIROUTPUT=0, one pulse -> 00; ENOUTPUT=0 pulses -> no change.
- BOOT_DONE_IN rises -> DIRINPUT=ENINPUT=1 after 2 cycles; exactly 16 STEPINPUT pulses 64 cycles apart, then low forever.
- Shoot-through (A1_H=A1=1) -> treated undriven, current decays.
